tape_fetch: RTL and testbench
=============================

TAPE_FETCH -- requirements
Module: tape_fetch

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in bytes, power of two, 2..16.
REQ-002 Parameter AW, default 23, SDRAM tape byte-address width.
REQ-003 clk_sys  in  1  system clock; single clock domain.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 load  in  1  one-cycle pulse at end of CDT download; latches tape_len and rewinds.
REQ-006 tape_len  in  AW  byte count of loaded image, sampled on load.
REQ-007 play  in  1  level; fetching permitted while high (tape motor on).
REQ-008 rewind  in  1  one-cycle pulse; restart from address 0.
REQ-009 tape_addr  out  AW  SDRAM tape read address, stable while a request is outstanding.
REQ-010 tape_rd  out  1  toggle request to SDRAM tape port.
REQ-011 tape_ack  in  1  toggle acknowledge; equals tape_rd when the request is complete.
REQ-012 tape_din  in  8  SDRAM read data, valid in the cycle tape_ack becomes equal to tape_rd.
REQ-013 byte_req  in  1  consumer pop strobe.
REQ-014 byte_out  out  8  FIFO head byte, first-word-fall-through.
REQ-015 byte_valid  out  1  FIFO non-empty.
REQ-016 fill  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 at_end  out  1  whole image delivered: address==length, FIFO empty, no request outstanding.

Function
REQ-018 FSM states SYNC, IDLE, WAIT; SYNC lasts one cycle, sets tape_rd to tape_ack, then enters IDLE.
REQ-019 IDLE->WAIT when play=1, addr<len, fill<DEPTH, no rewind/load this cycle; same edge toggles tape_rd and drives tape_addr=addr.
REQ-020 WAIT: on the first edge where tape_ack==tape_rd, write tape_din to FIFO, addr+1, go to IDLE.
REQ-021 At most one request outstanding; a slot is therefore always free when data returns.
REQ-022 Data written on edge N makes byte_valid=1 after edge N (1-cycle latency from ack match).
REQ-023 Pop occurs when byte_req & byte_valid; byte_req while empty is ignored, no underflow.
REQ-024 Simultaneous push and pop leaves fill unchanged and preserves byte order.
REQ-025 FIFO pointers wrap modulo DEPTH; fill saturates at DEPTH, never exceeding it.
REQ-026 play falling during WAIT does not abort; the byte is stored and no new request is issued.
REQ-027 load or rewind in IDLE: addr<=0, FIFO flushed, next edge eligible to issue.
REQ-028 load or rewind in WAIT: flush FIFO, addr<=0, set discard flag; the returning byte is dropped, not stored; then IDLE.
REQ-029 load and rewind in the same cycle act as load.
REQ-030 tape_len==0: no request ever issued; at_end=1 once FIFO empty.
REQ-031 addr is AW bits, compares unsigned against latched length; no wrap past length.

Reset
REQ-032 During reset_n=0: state SYNC, tape_rd=0, tape_addr=0, addr=0, latched length=0, FIFO empty, fill=0, byte_valid=0, byte_out=0, at_end=1, discard flag=0.
REQ-033 Deassertion is synchronized internally, with a 2-flop synchronizer; first active edge executes SYNC.

Structure
REQ-034 Shared package tape_pkg holds the state enum (SYNC, IDLE, WAIT) and the AW default constant.
REQ-035 One sub-module, tape_fifo (DEPTH x 8, FWFT, push/pop/flush/fill); tape_fetch holds FSM, address counter and handshake.

Verification
REQ-036 tape_len=5, play=1, SDRAM model acks after 3 cycles returning addr^8'hA5, consumer pops every cycle -> bytes A5,A4,A7,A6,A1 in order, then at_end=1, tape_rd toggled exactly 5 times.
REQ-037 tape_len=100, no pops -> exactly 4 requests issued, fill=4, tape_rd static; single pop -> one new request at tape_addr=4.
REQ-038 rewind asserted 1 cycle after request to addr 7 issued, ack at +5 -> returned byte not stored, fill=0, next request tape_addr=0.
REQ-039 Reset released with tape_ack=1 -> SYNC sets tape_rd=1, no spurious FIFO write, first request toggles tape_rd to 0.
REQ-040 FIFO full (fill=4), push and pop same edge cannot occur; at fill=3 simultaneous push+pop -> fill stays 3, order intact.
REQ-041 tape_len=0 with play=1 -> tape_rd never toggles, at_end=1 throughout.

Source files
------------

// File: rtl/tape_pkg.sv
// Shared definitions for the tape fetch block: FSM state encoding and
// the default SDRAM tape byte-address width.
package tape_pkg;

   localparam int TAPE_AW_DEFAULT = 23;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      IDLE = 2'd1,
      WAIT = 2'd2
   } tape_state_e;

endpackage

// File: rtl/tape_fetch_if.sv
// Toggle-handshake read port between the tape fetcher (master) and the
// SDRAM tape channel (slave).
interface tape_fetch_if
   import tape_pkg::*;
#(
   parameter int AW = TAPE_AW_DEFAULT
);

   logic [AW-1:0] tape_addr;
   logic          tape_rd;
   logic          tape_ack;
   logic [7:0]    tape_din;

   modport master (
      output tape_addr,
      output tape_rd,
      input  tape_ack,
      input  tape_din
   );

   modport slave (
      input  tape_addr,
      input  tape_rd,
      output tape_ack,
      output tape_din
   );

endinterface

// File: rtl/tape_fifo.sv
// Small first-word-fall-through byte FIFO with synchronous flush; the head
// byte reads as zero while the FIFO is empty.
module tape_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [DATA_W-1:0]      din,
   input  logic                   pop,
   input  logic                   flush,
   output logic [DATA_W-1:0]      dout,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] fill
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = PW + 1;
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [FW-1:0]     cnt_q, cnt_d;
   logic              do_push, do_pop;

   // A push into a full FIFO is only taken when the same edge frees a slot.
   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != FULL) || do_pop);
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PW'(1);
         if (do_pop)  rptr_d = rptr_q + PW'(1);
         if (do_push && !do_pop) begin
            cnt_d = cnt_q + FW'(1);
         end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - FW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wptr_q] <= din;
   end

   assign valid = (cnt_q != '0);
   assign dout  = valid ? mem_q[rptr_q] : '0;
   assign fill  = cnt_q;

endmodule

// File: rtl/tape_fetch.sv
// Streams a loaded tape image out of SDRAM one byte at a time over a toggle
// handshake and buffers it in a small FIFO for the tape consumer.
module tape_fetch
   import tape_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = TAPE_AW_DEFAULT
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic [AW-1:0]          tape_len,
   input  logic                   play,
   input  logic                   rewind,
   tape_fetch_if.master           sd,
   input  logic                   byte_req,
   output logic [7:0]             byte_out,
   output logic                   byte_valid,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   at_end
);

   localparam int FW = $clog2(DEPTH) + 1;
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic          rst_n_int;

   tape_state_e   state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] len_q, len_d;
   logic [AW-1:0] taddr_q, taddr_d;
   logic          rd_q, rd_d;
   logic          discard_q, discard_d;
   logic          restart;
   logic          push;
   logic          flush;

   // Reset asserts immediately but releases only after two clean edges.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n_int  = rst_sync_q[1];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= '0;
      else          rst_sync_q <= rst_sync_d;
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      taddr_d   = taddr_q;
      rd_d      = rd_q;
      discard_d = discard_q;
      push      = 1'b0;
      restart   = load | rewind;
      flush     = restart;

      if (load)    len_d  = tape_len;
      if (restart) addr_d = '0;

      case (state_q)
         SYNC: begin
            rd_d    = sd.tape_ack;
            state_d = IDLE;
         end
         IDLE: begin
            if (!restart && play && (addr_q < len_q) && (fill < FULL)) begin
               rd_d    = ~rd_q;
               taddr_d = addr_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A byte belonging to an image position abandoned by load/rewind is dropped.
            if (sd.tape_ack == rd_q) begin
               state_d   = IDLE;
               discard_d = 1'b0;
               if (!restart && !discard_q) begin
                  push   = 1'b1;
                  addr_d = addr_q + AW'(1);
               end
            end else if (restart) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q   <= SYNC;
         addr_q    <= '0;
         len_q     <= '0;
         taddr_q   <= '0;
         rd_q      <= 1'b0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         taddr_q   <= taddr_d;
         rd_q      <= rd_d;
         discard_q <= discard_d;
      end
   end

   tape_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk   (clk_sys),
      .rst_n (rst_n_int),
      .push  (push),
      .din   (sd.tape_din),
      .pop   (byte_req),
      .flush (flush),
      .dout  (byte_out),
      .valid (byte_valid),
      .fill  (fill)
   );

   assign sd.tape_addr = taddr_q;
   assign sd.tape_rd   = rd_q;
   assign at_end       = (addr_q == len_q) && !byte_valid && (state_q != WAIT);

endmodule

// File: tb/tb_tape_fetch.sv
// Bench for tape_fetch: an SDRAM responder with configurable latency and a
// byte-stream scoreboard that knows which image byte must come out next.
module tb_tape_fetch;
   import tape_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = TAPE_AW_DEFAULT;

   logic                   clk_sys  = 1'b0;
   logic                   reset_n  = 1'b0;
   logic                   load     = 1'b0;
   logic                   play     = 1'b0;
   logic                   rewind   = 1'b0;
   logic                   byte_req = 1'b0;
   logic [AW-1:0]          tape_len = '0;
   logic [7:0]             byte_out;
   logic                   byte_valid;
   logic [$clog2(DEPTH):0] fill;
   logic                   at_end;

   tape_fetch_if #(.AW(AW)) sd ();

   tape_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .load       (load),
      .tape_len   (tape_len),
      .play       (play),
      .rewind     (rewind),
      .sd         (sd),
      .byte_req   (byte_req),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .fill       (fill),
      .at_end     (at_end)
   );

   always #5 clk_sys = ~clk_sys;

   int         n_chk = 0;
   int         n_err = 0;
   int         exp_next = 0;    // image address the next request must carry
   int         pop_idx = 0;     // image index of the next byte the consumer must see
   int         len_m = 0;
   int         req_count = 0;
   int         pending = 0;
   int         lat_fixed = 0;
   int         req_addr = 0;
   logic       rd_at_req = 1'b0;
   bit         sd_en = 1'b0;
   bit         just_acked = 1'b0;
   bit         just_issued = 1'b0;
   logic [7:0] salt = 8'h00;

   function automatic logic [7:0] img(input int k);
      return 8'(k) ^ 8'hA5 ^ salt;
   endfunction

   task automatic expect_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic sdram_step();
      if (pending > 0) begin
         expect_eq("addr_stable", int'(sd.tape_addr), req_addr);
         expect_eq("rd_stable", int'(sd.tape_rd), int'(rd_at_req));
         pending--;
         if (pending == 0) begin
            sd.tape_ack = sd.tape_rd;
            sd.tape_din = img(req_addr);
            just_acked  = 1'b1;
         end
      end else if (sd.tape_rd !== sd.tape_ack) begin
         req_count++;
         just_issued = 1'b1;
         req_addr    = int'(sd.tape_addr);
         rd_at_req   = sd.tape_rd;
         expect_eq("req_addr", req_addr, exp_next);
         expect_eq("req_in_len", int'(req_addr < len_m), 1);
         exp_next++;
         pending = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
      end
   endtask

   task automatic tick();
      logic restart;
      @(posedge clk_sys);
      #1;
      restart = load | rewind;
      if (restart) begin
         exp_next = 0;
         pop_idx  = 0;
         if (load) len_m = int'(tape_len);
      end
      load        = 1'b0;
      rewind      = 1'b0;
      byte_req    = 1'b0;
      just_acked  = 1'b0;
      just_issued = 1'b0;
      if (sd_en) sdram_step();
      expect_eq("fill_bound", int'(int'(fill) <= DEPTH), 1);
      expect_eq("valid_vs_fill", int'(byte_valid), int'(fill != '0));
   endtask

   task automatic drive_pop();
      if (byte_valid) begin
         expect_eq("pop_data", int'(byte_out), int'(img(pop_idx)));
         pop_idx++;
      end
      byte_req = 1'b1;
   endtask

   task automatic load_pulse(input int len);
      tape_len = AW'(len);
      load     = 1'b1;
      tick();
   endtask

   task automatic do_reset(input logic ack0);
      sd_en       = 1'b0;
      pending     = 0;
      reset_n     = 1'b0;
      sd.tape_ack = ack0;
      sd.tape_din = 8'h00;
      play        = 1'b0;
      load        = 1'b0;
      rewind      = 1'b0;
      byte_req    = 1'b0;
      tick();
      tick();
      expect_eq("rst_rd", int'(sd.tape_rd), 0);
      expect_eq("rst_addr", int'(sd.tape_addr), 0);
      expect_eq("rst_valid", int'(byte_valid), 0);
      expect_eq("rst_fill", int'(fill), 0);
      expect_eq("rst_out", int'(byte_out), 0);
      expect_eq("rst_at_end", int'(at_end), 1);
      reset_n = 1'b1;
      repeat (4) tick();
      expect_eq("sync_rd", int'(sd.tape_rd), int'(ack0));
      expect_eq("sync_valid", int'(byte_valid), 0);
      expect_eq("sync_at_end", int'(at_end), 1);
      exp_next = 0;
      pop_idx  = 0;
      len_m    = 0;
      sd_en    = 1'b1;
   endtask

   initial begin
      int  base;
      bit  ok;
      logic rd_s;

      do_reset(1'b0);

      // Empty image: nothing is ever requested.
      load_pulse(0);
      play = 1'b1;
      base = req_count;
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_eq("len0_at_end", int'(at_end), 1);
         drive_pop();
      end
      expect_eq("len0_no_req", req_count - base, 0);

      // Five-byte image, fixed 3-cycle SDRAM latency, consumer always popping.
      lat_fixed = 3;
      load_pulse(5);
      base = req_count;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (at_end && pop_idx == len_m) begin ok = 1'b1; break; end
         drive_pop();
      end
      expect_eq("len5_done", int'(ok), 1);
      expect_eq("len5_toggles", req_count - base, 5);
      expect_eq("len5_popped", pop_idx, 5);

      // Long image with no consumer: fetching stops once the FIFO is full.
      lat_fixed = 2;
      load_pulse(100);
      base = req_count;
      repeat (40) tick();
      expect_eq("full_reqs", req_count - base, 4);
      expect_eq("full_fill", int'(fill), 4);
      rd_s = sd.tape_rd;
      repeat (10) tick();
      expect_eq("full_rd_static", int'(sd.tape_rd), int'(rd_s));
      expect_eq("full_no_more", req_count - base, 4);
      drive_pop();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (just_issued) begin ok = 1'b1; break; end
      end
      expect_eq("pop1_reissue", int'(ok), 1);
      expect_eq("pop1_addr", req_addr, 4);
      repeat (10) tick();
      expect_eq("pop1_fill", int'(fill), 4);
      expect_eq("pop1_reqs", req_count - base, 5);

      // Rewind while the request for address 7 is in flight.
      lat_fixed = 5;
      load_pulse(100);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (just_issued && req_addr == 7) begin ok = 1'b1; break; end
         drive_pop();
      end
      expect_eq("rew_saw_addr7", int'(ok), 1);
      rewind = 1'b1;
      tick();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (just_acked) begin ok = 1'b1; break; end
      end
      expect_eq("rew_ack_seen", int'(ok), 1);
      tick();
      expect_eq("rew_fill", int'(fill), 0);
      expect_eq("rew_valid", int'(byte_valid), 0);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (just_issued) begin ok = 1'b1; break; end
         tick();
      end
      expect_eq("rew_reissue", int'(ok), 1);
      expect_eq("rew_next_addr", req_addr, 0);
      for (int i = 0; i < 40 && pop_idx < 1; i++) begin
         tick();
         drive_pop();
      end
      expect_eq("rew_first_pop", pop_idx, 1);

      // Push and pop on the same edge at fill=3.
      lat_fixed = 2;
      load_pulse(100);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (just_acked && fill == 3) begin ok = 1'b1; break; end
      end
      expect_eq("pp_setup", int'(ok), 1);
      drive_pop();
      tick();
      expect_eq("pp_fill", int'(fill), 3);
      play = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (pending == 0 && !byte_valid) break;
         drive_pop();
         tick();
      end
      expect_eq("pp_order_count", pop_idx, 4);
      expect_eq("pp_drained", int'(byte_valid), 0);

      // Reset released with ack high: SYNC aligns tape_rd, first request drives it low.
      do_reset(1'b1);
      lat_fixed = 0;
      load_pulse(3);
      play = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (just_issued) begin ok = 1'b1; break; end
      end
      expect_eq("ackhi_issue", int'(ok), 1);
      expect_eq("ackhi_first_rd", int'(sd.tape_rd), 0);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (at_end && pop_idx == len_m) begin ok = 1'b1; break; end
         drive_pop();
         tick();
      end
      expect_eq("ackhi_done", int'(ok), 1);
      expect_eq("ackhi_popped", pop_idx, 3);

      // Randomized play, consumer, latency and rewinds.
      for (int it = 0; it < 4; it++) begin
         salt      = 8'($urandom);
         lat_fixed = 0;
         load_pulse(int'($urandom_range(0, 24)));
         for (int i = 0; i < 300; i++) begin
            tick();
            play = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 79) == 0) rewind = 1'b1;
            else if ($urandom_range(0, 1) == 1) drive_pop();
         end
         play = 1'b1;
         ok = 1'b0;
         for (int i = 0; i < 800; i++) begin
            tick();
            if (at_end && pop_idx == len_m) begin ok = 1'b1; break; end
            drive_pop();
         end
         expect_eq("rnd_at_end", int'(ok), 1);
         expect_eq("rnd_count", pop_idx, len_m);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
